// File: rtl/lanceur_pkg.sv
// Shared types and helpers for the dice-launcher roll controller.
package lanceur_pkg;

  localparam int unsigned VAL_W   = 7;
  localparam int unsigned CHOIX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SHOW,
    ERR
  } state_t;

  // True when exactly one die is selected.
  function automatic logic onehot_ok(input logic [CHOIX_W-1:0] choix);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < CHOIX_W; i++) begin
      n = n + {31'd0, choix[i]};
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/lanceur_sequenceur_if.sv
// Signal bundle between the roll controller, the launch button, the random counter and the display.
interface lanceur_sequenceur_if;
  import lanceur_pkg::*;

  logic               BLancer;
  logic [CHOIX_W-1:0] Choix;
  logic [VAL_W-1:0]   ValCPT;
  logic [VAL_W-1:0]   ValMin;
  logic [VAL_W-1:0]   ValMax;
  logic [VAL_W-1:0]   Result;
  logic               ResValid;
  logic               Rolling;
  logic               Err;

  modport master (
    output BLancer, Choix, ValCPT, ValMin, ValMax,
    input  Result, ResValid, Rolling, Err
  );

  modport slave (
    input  BLancer, Choix, ValCPT, ValMin, ValMax,
    output Result, ResValid, Rolling, Err
  );

endinterface

// File: rtl/lanceur_debounce.sv
// Launch button conditioning: 2-flop synchroniser, stability-count debouncer and a
// single-cycle pulse on the debounced rising edge.
module lanceur_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  logic        sync1, sync2;
  logic        level, level_d;
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      // Any cycle where the synced input matches the level restarts the count.
      if (sync2 != level) begin
        if (cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lanceur_sequenceur.sv
// Dice-launcher roll controller: animates the random counter, then latches the final draw.
// Optional LANCEUR_SLOWDOWN_EN: step interval grows by STEP_CYCLES every 4 steps.
module lanceur_sequenceur
  import lanceur_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ROLL_STEPS      = 16,
  parameter int unsigned STEP_CYCLES     = 2500000
) (
  input  logic                 ClkIn,
  input  logic                 RstIn,
  lanceur_sequenceur_if.slave  bus
);

  localparam int unsigned      STEP_W    = $clog2(ROLL_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ROLL_STEPS - 1);

  logic               launch;
  logic [CHOIX_W-1:0] choix_q, choix_prev;
  logic               choix_ok, choix_chg;
  state_t             state, state_n;
  logic [STEP_W-1:0]  step, step_n;
  logic [31:0]        timer, timer_n;
  logic [31:0]        interval;
  logic [VAL_W-1:0]   result, result_n;
  logic               res_valid, res_valid_n;
  logic               wrap, in_range;

  lanceur_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (ClkIn),
    .rst  (RstIn),
    .raw  (bus.BLancer),
    .rise (launch)
  );

  // Choix pipeline is left unreset so it tracks the switches through a reset pulse
  // and no spurious change/error is seen when reset releases.
  always_ff @(posedge ClkIn) begin
    choix_q    <= bus.Choix;
    choix_prev <= choix_q;
  end

  assign choix_ok  = onehot_ok(choix_q);
  assign choix_chg = (choix_q != choix_prev);
  assign wrap      = (timer == interval - 32'd1);
  assign in_range  = (bus.ValCPT >= bus.ValMin) && (bus.ValCPT <= bus.ValMax);

`ifdef LANCEUR_SLOWDOWN_EN
  logic [31:0] interval_n;

  always_ff @(posedge ClkIn) begin
    if (RstIn) interval <= 32'(STEP_CYCLES);
    else       interval <= interval_n;
  end
`else
  assign interval = 32'(STEP_CYCLES);
`endif

  always_comb begin
    state_n     = state;
    step_n      = step;
    timer_n     = timer;
    result_n    = result;
    res_valid_n = res_valid;
`ifdef LANCEUR_SLOWDOWN_EN
    interval_n  = interval;
`endif
    if (!choix_ok) begin
      state_n     = ERR;
      step_n      = '0;
      timer_n     = '0;
      result_n    = '0;
      res_valid_n = 1'b0;
    end else if (choix_chg) begin
      state_n     = IDLE;
      step_n      = '0;
      timer_n     = '0;
      result_n    = '0;
      res_valid_n = 1'b0;
    end else begin
      unique case (state)
        IDLE, SHOW: begin
          if (launch) begin
            state_n     = ROLL;
            step_n      = '0;
            timer_n     = '0;
            res_valid_n = 1'b0;
`ifdef LANCEUR_SLOWDOWN_EN
            interval_n  = 32'(STEP_CYCLES);
`endif
          end
        end
        ROLL: begin
          if (!wrap) begin
            timer_n = timer + 32'd1;
          end else begin
            if (in_range) result_n = bus.ValCPT;
            // On the last step the timer stays wrapped, so every cycle re-samples
            // until the counter lands in range.
            if (step == LAST_STEP) begin
              if (in_range) begin
                state_n     = SHOW;
                res_valid_n = 1'b1;
                timer_n     = '0;
              end
            end else begin
              step_n  = step + STEP_W'(1);
              timer_n = '0;
`ifdef LANCEUR_SLOWDOWN_EN
              if (((32'(step) + 32'd1) & 32'd3) == 32'd0)
                interval_n = interval + 32'(STEP_CYCLES);
`endif
            end
          end
        end
        ERR: begin
          state_n  = IDLE;
          result_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge ClkIn) begin
    if (RstIn) begin
      state     <= IDLE;
      step      <= '0;
      timer     <= '0;
      result    <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      timer     <= timer_n;
      result    <= result_n;
      res_valid <= res_valid_n;
    end
  end

  assign bus.Result   = result;
  assign bus.ResValid = res_valid;
  assign bus.Rolling  = (state == ROLL);
  assign bus.Err      = (state == ERR);

endmodule

// File: tb/tb_lanceur_sequenceur.sv
// Bench for lanceur_sequenceur: directed scenario with randomized counter values,
// expectations from a sample-schedule model of the roll.
module tb_lanceur_sequenceur;

  localparam int unsigned DEB = 4;
  localparam int unsigned SC  = 3;
`ifdef LANCEUR_SLOWDOWN_EN
  localparam int unsigned RS  = 8;
`else
  localparam int unsigned RS  = 4;
`endif
  // 2 synchroniser flops + stability count + pulse register + FSM register
  localparam int LAUNCH_LAT = 2 + DEB + 2;

  logic ClkIn = 1'b0;
  logic RstIn = 1'b1;
  lanceur_sequenceur_if bus();

  lanceur_sequenceur #(
    .DEBOUNCE_CYCLES(DEB),
    .ROLL_STEPS     (RS),
    .STEP_CYCLES    (SC)
  ) dut (
    .ClkIn (ClkIn),
    .RstIn (RstIn),
    .bus   (bus)
  );

  always #5 ClkIn = ~ClkIn;

  int         total  = 0;
  int         passed = 0;
  int         failed = 0;
  logic [6:0] exp_res = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClkIn);
    #1;
  endtask

  function automatic int interval(input int k);
`ifdef LANCEUR_SLOWDOWN_EN
    return SC * (1 + k / 4);
`else
    return SC;
`endif
  endfunction

  task automatic press_and_wait(input string tag);
    int lat;
    bus.BLancer = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.Rolling && lat < 60);
    check(tag, lat, LAUNCH_LAT);
  endtask

  task automatic release_btn();
    bus.BLancer = 1'b0;
    for (int i = 0; i < int'(DEB) + 6; i++) tick();
    check("release_idle", bus.Rolling, 1'b0);
    check("release_result", bus.Result, exp_res);
  endtask

  // Called in the first cycle where Rolling is seen high; the counter is sampled at
  // the end of cycle j whenever j+1 equals a running sum of step intervals.
  task automatic run_roll(input logic [6:0] vmin, input logic [6:0] vmax,
                          input bit force_mid, input bit force_final);
    int unsigned vals[256];
    bit          is_pt[256];
    int          pt, final_pt;
    bit          done, inr;
    bus.ValMin = vmin;
    bus.ValMax = vmax;
    pt = 0;
    for (int i = 0; i < 256; i++) is_pt[i] = 1'b0;
    for (int k = 0; k < int'(RS); k++) begin
      pt += interval(k);
      if (k < int'(RS) - 1) is_pt[pt-1] = 1'b1;
    end
    final_pt = pt - 1;
    for (int i = 0; i < 256; i++) vals[i] = $urandom_range(0, int'(vmax) + 1);
    if (force_mid) vals[interval(0) - 1] = 0;
    if (force_final) begin
      vals[final_pt]     = 0;
      vals[final_pt + 1] = 3;
    end
    vals[final_pt + 4] = vmin;
    done = 1'b0;
    for (int j = 0; j < 200 && !done; j++) begin
      bus.ValCPT = vals[j][6:0];
      inr = (vals[j] >= vmin) && (vals[j] <= vmax);
      if (j >= final_pt) begin
        if (inr) begin
          exp_res = vals[j][6:0];
          done    = 1'b1;
        end
      end else if (is_pt[j] && inr) begin
        exp_res = vals[j][6:0];
      end
      tick();
      check("roll_result", bus.Result, exp_res);
      check("roll_valid", bus.ResValid, done);
      check("roll_busy", bus.Rolling, !done);
    end
    if (!done) check("roll_timeout", 0, 1);
  endtask

  initial begin
    bus.BLancer = 1'b0;
    bus.Choix   = 8'h02;
    bus.ValCPT  = 7'd1;
    bus.ValMin  = 7'd1;
    bus.ValMax  = 7'd6;

    // Reset values
    for (int i = 0; i < 3; i++) tick();
    check("rst_result", bus.Result, 0);
    check("rst_valid", bus.ResValid, 0);
    check("rst_rolling", bus.Rolling, 0);
    check("rst_err", bus.Err, 0);
    RstIn = 1'b0;
    tick();
    tick();
    check("idle_err", bus.Err, 0);

    // Bounce 1,0 on 3-cycle runs, then held: one launch after the final stable run
    bus.BLancer = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.BLancer = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("bounce_no_launch", bus.Rolling, 0);
    press_and_wait("bounce_launch_lat");
    check("roll_start_result", bus.Result, exp_res);
    run_roll(7'd1, 7'd6, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("hold_no_retrigger", bus.Rolling, 0);
    check("hold_valid", bus.ResValid, 1);
    check("hold_result", bus.Result, exp_res);
    release_btn();
    check("show_after_release", bus.ResValid, 1);

    // Relaunch from SHOW, final sample out of range then 3
    press_and_wait("relaunch_lat");
    check("relaunch_valid_clr", bus.ResValid, 0);
    check("relaunch_result_kept", bus.Result, exp_res);
    run_roll(7'd1, 7'd6, 1'b0, 1'b1);
    check("oor_final_result", bus.Result, 3);
    release_btn();

    // Reset in the middle of a roll
    press_and_wait("pre_reset_lat");
    bus.ValCPT = 7'd5;
    for (int i = 0; i < 4; i++) tick();
    RstIn       = 1'b1;
    bus.BLancer = 1'b0;
    tick();
    exp_res = '0;
    check("midrst_result", bus.Result, 0);
    check("midrst_valid", bus.ResValid, 0);
    check("midrst_rolling", bus.Rolling, 0);
    RstIn = 1'b0;
    release_btn();
    check("midrst_err", bus.Err, 0);

    // Invalid Choix aborts a roll; launches ignored in ERR
    press_and_wait("err_roll_lat");
    for (int i = 0; i < 3; i++) tick();
    bus.Choix = 8'h03;
    tick();
    tick();
    check("abort_err", bus.Err, 1);
    check("abort_result", bus.Result, 0);
    check("abort_rolling", bus.Rolling, 0);
    check("abort_valid", bus.ResValid, 0);
    release_btn();
    bus.BLancer = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("err_ignores_launch", bus.Rolling, 0);
    check("err_held", bus.Err, 1);
    release_btn();
    bus.Choix = 8'h04;
    tick();
    tick();
    check("recover_err", bus.Err, 0);
    check("recover_result", bus.Result, 0);

    // d4 roll, then Choix change in SHOW
    press_and_wait("d4_lat");
    run_roll(7'd1, 7'd4, 1'b0, 1'b0);
    bus.Choix = 8'h08;
    tick();
    tick();
    exp_res = '0;
    check("chg_show_valid", bus.ResValid, 0);
    check("chg_show_result", bus.Result, 0);
    check("chg_show_err", bus.Err, 0);
    check("chg_show_rolling", bus.Rolling, 0);
    release_btn();

    // Zero bits selected
    bus.Choix = 8'h00;
    tick();
    tick();
    check("zero_choix_err", bus.Err, 1);
    bus.Choix = 8'h02;
    tick();
    tick();
    check("zero_choix_recover", bus.Err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
